// File: rtl/mem_port_arbiter_if.sv
// Bundle for the CPU port, the DMA/loader port and the shared single-port RAM.
// The arbiter uses the slave view; the requesters and the RAM sit on the master view.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16,
   parameter int RAM_AW = 8
);
   logic [1:0]        cpu_cmd;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ready;
   logic [1:0]        dma_cmd;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic [DATA_W-1:0] dma_rdata;
   logic              dma_ready;
   logic [RAM_AW-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_write;
   logic [DATA_W-1:0] ram_rdata;
   logic [1:0]        owner;

   modport slave (
      input  cpu_cmd, cpu_addr, cpu_wdata, dma_cmd, dma_addr, dma_wdata, ram_rdata,
      output cpu_rdata, cpu_ready, dma_rdata, dma_ready, ram_addr, ram_wdata, ram_write, owner
   );

   modport master (
      output cpu_cmd, cpu_addr, cpu_wdata, dma_cmd, dma_addr, dma_wdata, ram_rdata,
      input  cpu_rdata, cpu_ready, dma_rdata, dma_ready, ram_addr, ram_wdata, ram_write, owner
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM between CPU and DMA ports; ready pulses at
// +1 (out of range), +2 (write), +3 (read) after the sampling IDLE cycle; requests wait while busy.
module mem_port_arbiter #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16,
   parameter int RAM_AW = 8
) (
   input logic                clk,
   input logic                reset,
   mem_port_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_CAPTURE, S_DONE} state_t;

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_CPU  = 2'b01;
   localparam logic [1:0] OWN_DMA  = 2'b10;
   localparam logic [1:0] CMD_RD   = 2'b01;
   localparam logic [1:0] CMD_WR   = 2'b10;

   state_t              r_state;
   logic [1:0]          r_owner;
   logic                r_last_dma;
   logic                r_is_write;
   logic                r_cpu_ready;
   logic                r_dma_ready;
   logic                r_ram_write;
   logic [DATA_W-1:0]   r_cpu_rdata;
   logic [DATA_W-1:0]   r_dma_rdata;
   logic [DATA_W-1:0]   r_ram_wdata;
   logic [RAM_AW-1:0]   r_ram_addr;

   logic                w_cpu_vld;
   logic                w_dma_vld;
   logic                w_grant_dma;
   logic [1:0]          w_sel_cmd;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [DATA_W-1:0]   w_sel_wdata;
   logic                w_sel_write;
   logic                w_sel_oor;

   always_comb begin
      w_cpu_vld   = (bus.cpu_cmd == CMD_RD) || (bus.cpu_cmd == CMD_WR);
      w_dma_vld   = (bus.dma_cmd == CMD_RD) || (bus.dma_cmd == CMD_WR);
      // On a tie, the requester that was not served last wins.
      w_grant_dma = w_dma_vld && (!w_cpu_vld || !r_last_dma);
      w_sel_cmd   = w_grant_dma ? bus.dma_cmd   : bus.cpu_cmd;
      w_sel_addr  = w_grant_dma ? bus.dma_addr  : bus.cpu_addr;
      w_sel_wdata = w_grant_dma ? bus.dma_wdata : bus.cpu_wdata;
      w_sel_write = (w_sel_cmd == CMD_WR);
      w_sel_oor   = w_sel_addr[ADDR_W-1];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_owner     <= OWN_NONE;
         r_last_dma  <= 1'b1;
         r_is_write  <= 1'b0;
         r_cpu_ready <= 1'b0;
         r_dma_ready <= 1'b0;
         r_ram_write <= 1'b0;
         r_cpu_rdata <= '0;
         r_dma_rdata <= '0;
         r_ram_wdata <= '0;
         r_ram_addr  <= '0;
      end else begin
         r_cpu_ready <= 1'b0;
         r_dma_ready <= 1'b0;
         r_ram_write <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_cpu_vld || w_dma_vld) begin
                  r_owner    <= w_grant_dma ? OWN_DMA : OWN_CPU;
                  r_last_dma <= w_grant_dma;
                  r_is_write <= w_sel_write;
                  if (w_sel_oor) begin
                     // Out-of-range: complete at once, reads return zero.
                     if (!w_sel_write) begin
                        if (w_grant_dma) r_dma_rdata <= '0;
                        else             r_cpu_rdata <= '0;
                     end
                     r_cpu_ready <= !w_grant_dma;
                     r_dma_ready <= w_grant_dma;
                     r_state     <= S_DONE;
                  end else begin
                     r_ram_addr  <= w_sel_addr[RAM_AW-1:0];
                     r_ram_wdata <= w_sel_wdata;
                     r_ram_write <= w_sel_write;
                     r_state     <= S_ACCESS;
                  end
               end
            end
            S_ACCESS: begin
               if (r_is_write) begin
                  r_cpu_ready <= (r_owner == OWN_CPU);
                  r_dma_ready <= (r_owner == OWN_DMA);
                  r_state     <= S_DONE;
               end else begin
                  r_state     <= S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               if (r_owner == OWN_DMA) r_dma_rdata <= bus.ram_rdata;
               else                    r_cpu_rdata <= bus.ram_rdata;
               r_cpu_ready <= (r_owner == OWN_CPU);
               r_dma_ready <= (r_owner == OWN_DMA);
               r_state     <= S_DONE;
            end
            S_DONE: begin
               r_owner <= OWN_NONE;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.cpu_rdata = r_cpu_rdata;
   assign bus.cpu_ready = r_cpu_ready;
   assign bus.dma_rdata = r_dma_rdata;
   assign bus.dma_ready = r_dma_ready;
   assign bus.ram_addr  = r_ram_addr;
   assign bus.ram_wdata = r_ram_wdata;
   assign bus.ram_write = r_ram_write;
   assign bus.owner     = r_owner;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random request pairs against a
// transaction-level model (arbitration order, latency, memory contents).
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_port_arbiter_if bus ();
   mem_port_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

   // Synchronous single-port RAM seen by the arbiter.
   bit [15:0] ram [256];
   always @(posedge clk) begin
      if (bus.ram_write) ram[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= ram[bus.ram_addr];
   end

   bit [15:0]   ref_mem [256];
   bit          m_last_dma;
   int          n_checks;
   int          n_errors;
   logic [7:0]  wr_addr_seen;
   logic [15:0] wr_data_seen;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int op_lat(input logic [1:0] cmd, input logic [8:0] addr);
      if (addr[8]) return 1;
      return (cmd == 2'b10) ? 2 : 3;
   endfunction

   function automatic bit is_vld(input logic [1:0] cmd);
      return (cmd == 2'b01) || (cmd == 2'b10);
   endfunction

   // Drives one CPU and one DMA command in the same IDLE cycle and checks the outcome.
   task automatic run_pair(input logic [1:0] cc, input logic [8:0] ca, input logic [15:0] cw,
                           input logic [1:0] dc, input logic [8:0] da, input logic [15:0] dw);
      logic [1:0]  cmd [2];
      logic [8:0]  addr [2];
      logic [15:0] wd [2];
      bit          vld [2];
      int          exp_lat [2];
      int          exp_start [2];
      logic [15:0] exp_rd [2];
      int          seen_cnt [2];
      int          seen_lat [2];
      logic [15:0] seen_rd [2];
      logic [1:0]  own_hist [32];
      int          first, k, t, exp_wr, wr_cnt, end_cyc;
      cmd[0] = cc; addr[0] = ca; wd[0] = cw;
      cmd[1] = dc; addr[1] = da; wd[1] = dw;
      for (int i = 0; i < 2; i++) begin
         vld[i] = is_vld(cmd[i]);
         exp_lat[i] = 0; exp_start[i] = 0; exp_rd[i] = '0;
         seen_cnt[i] = 0; seen_lat[i] = 0; seen_rd[i] = '0;
      end
      for (int i = 0; i < 32; i++) own_hist[i] = 2'b00;
      first = (vld[0] && vld[1]) ? (m_last_dma ? 0 : 1) : (vld[1] ? 1 : 0);
      t = 0; exp_wr = 0; wr_cnt = 0;
      for (int n = 0; n < 2; n++) begin
         k = (n == 0) ? first : 1 - first;
         if (vld[k]) begin
            exp_start[k] = t;
            exp_lat[k]   = t + op_lat(cmd[k], addr[k]);
            t            = exp_lat[k] + 1;
            if (addr[k][8])            exp_rd[k] = '0;
            else if (cmd[k] == 2'b10) begin
               ref_mem[addr[k][7:0]] = wd[k];
               exp_wr++;
            end else                   exp_rd[k] = ref_mem[addr[k][7:0]];
            m_last_dma = (k == 1);
         end
      end
      end_cyc = t + 3;

      bus.cpu_cmd = cc; bus.cpu_addr = ca; bus.cpu_wdata = cw;
      bus.dma_cmd = dc; bus.dma_addr = da; bus.dma_wdata = dw;
      for (int c = 1; c <= end_cyc; c++) begin
         step();
         own_hist[c] = bus.owner;
         if (bus.ram_write) begin
            wr_cnt++;
            wr_addr_seen = bus.ram_addr;
            wr_data_seen = bus.ram_wdata;
         end
         if (bus.cpu_ready) begin
            seen_cnt[0]++; seen_lat[0] = c; seen_rd[0] = bus.cpu_rdata; bus.cpu_cmd = 2'b00;
         end
         if (bus.dma_ready) begin
            seen_cnt[1]++; seen_lat[1] = c; seen_rd[1] = bus.dma_rdata; bus.dma_cmd = 2'b00;
         end
      end
      bus.cpu_cmd = 2'b00;
      bus.dma_cmd = 2'b00;

      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (seen_cnt[i] !== (vld[i] ? 1 : 0)) begin
            n_errors++;
            $display("FAIL ready_count[%0d]: got %0d expected %0d", i, seen_cnt[i], vld[i] ? 1 : 0);
         end
         if (vld[i]) begin
            n_checks++;
            if (seen_lat[i] !== exp_lat[i]) begin
               n_errors++;
               $display("FAIL ready_latency[%0d]: got %0d expected %0d", i, seen_lat[i], exp_lat[i]);
            end
            n_checks++;
            if (own_hist[exp_start[i] + 1] !== ((i == 1) ? 2'b10 : 2'b01)) begin
               n_errors++;
               $display("FAIL owner[%0d]: got %0d expected %0d", i, own_hist[exp_start[i] + 1],
                        (i == 1) ? 2 : 1);
            end
            if (cmd[i] == 2'b01) begin
               n_checks++;
               if (seen_rd[i] !== exp_rd[i]) begin
                  n_errors++;
                  $display("FAIL rdata[%0d]: got %h expected %h", i, seen_rd[i], exp_rd[i]);
               end
            end
         end
      end
      n_checks++;
      if (wr_cnt !== exp_wr) begin
         n_errors++;
         $display("FAIL ram_write_cycles: got %0d expected %0d", wr_cnt, exp_wr);
      end
      n_checks++;
      if (bus.owner !== 2'b00) begin
         n_errors++;
         $display("FAIL owner_idle: got %0d expected 0", bus.owner);
      end
   endtask

   task automatic test_reset();
      logic [63:0] got;
      got = {bus.cpu_rdata, bus.dma_rdata, bus.ram_wdata, bus.ram_addr,
             bus.cpu_ready, bus.dma_ready, bus.ram_write, bus.owner, 3'b000};
      n_checks++;
      if (got !== 64'd0) begin
         n_errors++;
         $display("FAIL reset_outputs: got %h expected 0", got);
      end
      reset = 1'b1;
      step();
      n_checks++;
      if ({bus.owner, bus.cpu_ready, bus.dma_ready} !== 4'b0000) begin
         n_errors++;
         $display("FAIL post_reset_idle: got %b expected 0000", {bus.owner, bus.cpu_ready, bus.dma_ready});
      end
   endtask

   task automatic test_tie();
      run_pair(2'b01, 9'h020, 16'h0, 2'b01, 9'h021, 16'h0);
   endtask

   task automatic test_hold_alternate();
      bit          first_dma;
      logic [1:0]  own [13];
      bit          crdy [13];
      bit          drdy [13];
      logic [1:0]  exp_own;
      bit          exp_c, exp_d;
      first_dma = !m_last_dma;
      bus.cpu_cmd = 2'b01; bus.cpu_addr = 9'h030;
      bus.dma_cmd = 2'b01; bus.dma_addr = 9'h031;
      for (int c = 1; c <= 12; c++) begin
         step();
         own[c] = bus.owner; crdy[c] = bus.cpu_ready; drdy[c] = bus.dma_ready;
         if (c == 11) begin
            bus.cpu_cmd = 2'b00;
            bus.dma_cmd = 2'b00;
         end
      end
      for (int g = 0; g < 3; g++) begin
         exp_own = ((g == 1) ^ first_dma) ? 2'b10 : 2'b01;
         exp_c   = (exp_own == 2'b01);
         exp_d   = (exp_own == 2'b10);
         n_checks++;
         if (own[4 * g + 1] !== exp_own) begin
            n_errors++;
            $display("FAIL hold_owner[%0d]: got %0d expected %0d", g, own[4 * g + 1], exp_own);
         end
         n_checks++;
         if ({crdy[4 * g + 3], drdy[4 * g + 3]} !== {exp_c, exp_d}) begin
            n_errors++;
            $display("FAIL hold_ready[%0d]: got %b expected %b", g,
                     {crdy[4 * g + 3], drdy[4 * g + 3]}, {exp_c, exp_d});
         end
      end
      m_last_dma = first_dma;
      n_checks++;
      if (bus.cpu_rdata !== ref_mem[8'h30] || bus.dma_rdata !== ref_mem[8'h31]) begin
         n_errors++;
         $display("FAIL hold_rdata: got %h/%h expected %h/%h", bus.cpu_rdata, bus.dma_rdata,
                  ref_mem[8'h30], ref_mem[8'h31]);
      end
   endtask

   task automatic test_write_read();
      run_pair(2'b10, 9'h010, 16'hBEEF, 2'b00, 9'h000, 16'h0);
      n_checks++;
      if ({wr_addr_seen, wr_data_seen} !== {8'h10, 16'hBEEF}) begin
         n_errors++;
         $display("FAIL write_bus: got %h/%h expected 10/beef", wr_addr_seen, wr_data_seen);
      end
      run_pair(2'b01, 9'h010, 16'h0, 2'b00, 9'h000, 16'h0);
      n_checks++;
      if (bus.cpu_rdata !== 16'hBEEF) begin
         n_errors++;
         $display("FAIL read_back: got %h expected beef", bus.cpu_rdata);
      end
   endtask

   task automatic test_out_of_range();
      run_pair(2'b00, 9'h000, 16'h0, 2'b01, 9'h010, 16'h0);
      run_pair(2'b00, 9'h000, 16'h0, 2'b10, 9'h140, 16'h1234);
      run_pair(2'b00, 9'h000, 16'h0, 2'b01, 9'h1FF, 16'h0);
      n_checks++;
      if (bus.dma_rdata !== 16'h0000) begin
         n_errors++;
         $display("FAIL oor_read: got %h expected 0000", bus.dma_rdata);
      end
   endtask

   task automatic test_cmd11();
      int events;
      events = 0;
      bus.cpu_cmd = 2'b11; bus.dma_cmd = 2'b11;
      for (int c = 0; c < 10; c++) begin
         step();
         if (bus.cpu_ready || bus.dma_ready || bus.ram_write || bus.owner != 2'b00) events++;
      end
      bus.cpu_cmd = 2'b00; bus.dma_cmd = 2'b00;
      n_checks++;
      if (events !== 0) begin
         n_errors++;
         $display("FAIL cmd11_activity: got %0d expected 0", events);
      end
   endtask

   task automatic test_reset_mid_access();
      int readys;
      readys = 0;
      bus.cpu_cmd = 2'b10; bus.cpu_addr = 9'h055; bus.cpu_wdata = 16'h1234;
      step();
      n_checks++;
      if (bus.ram_write !== 1'b1) begin
         n_errors++;
         $display("FAIL access_write: got %b expected 1", bus.ram_write);
      end
      reset = 1'b0;
      #1;
      n_checks++;
      if ({bus.ram_write, bus.cpu_ready, bus.owner} !== 4'b0000) begin
         n_errors++;
         $display("FAIL reset_abort: got %b expected 0000", {bus.ram_write, bus.cpu_ready, bus.owner});
      end
      bus.cpu_cmd = 2'b00;
      for (int c = 0; c < 3; c++) begin
         step();
         if (bus.cpu_ready || bus.dma_ready) readys++;
      end
      reset = 1'b1;
      m_last_dma = 1'b1;
      step();
      if (bus.cpu_ready || bus.dma_ready) readys++;
      n_checks++;
      if (readys !== 0) begin
         n_errors++;
         $display("FAIL reset_no_ready: got %0d expected 0", readys);
      end
      n_checks++;
      if ({bus.cpu_rdata, bus.dma_rdata, bus.owner} !== 34'd0) begin
         n_errors++;
         $display("FAIL reset_regs: got %h expected 0", {bus.cpu_rdata, bus.dma_rdata, bus.owner});
      end
      // Aborted write must not have reached memory; tie after reset goes to CPU again.
      run_pair(2'b01, 9'h055, 16'h0, 2'b10, 9'h056, 16'hA5A5);
   endtask

   task automatic test_random();
      logic [1:0]  cc, dc;
      logic [8:0]  ca, da;
      for (int i = 0; i < 150; i++) begin
         cc = 2'($urandom_range(0, 3));
         dc = 2'($urandom_range(0, 3));
         ca = {($urandom_range(0, 4) == 0), 3'b000, 5'($urandom_range(0, 31))};
         da = {($urandom_range(0, 4) == 0), 3'b000, 5'($urandom_range(0, 31))};
         run_pair(cc, ca, 16'($urandom), dc, da, 16'($urandom));
      end
   endtask

   initial begin
      n_checks = 0; n_errors = 0; m_last_dma = 1'b1;
      bus.cpu_cmd = 2'b00; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.dma_cmd = 2'b00; bus.dma_addr = '0; bus.dma_wdata = '0;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_tie();
      test_hold_alternate();
      test_write_read();
      test_out_of_range();
      test_cmd11();
      test_reset_mid_access();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
